// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-requester arbiter and command sequencer for a single-port 8k x 32
// synchronous SRAM. Requester m0 is the boot loader and m1 is the core.
// Each accepted request becomes a one-cycle command (CMD). A read adds one
// response cycle (RESP), in which the SRAM's registered read-done strobe
// (mem_oe_r) qualifies the captured data.
//
// Transaction timing, where N is the first cycle a request is seen in IDLE:
//   N+1 : grant pulse and SRAM command cycle
//   N+2 : write -> back in IDLE; read -> RESP, data captured at end of cycle
//   N+3 : read  -> rvalid pulse, back in IDLE
//
// Configuration macro:
//   SRAM_ARB_FIXED_PRIO_EN  defined   : fixed priority, m0 wins every tie
//                           undefined : round-robin using last_gnt_q
//
// Ports:
//   sram_clk            clock, shared with the SRAM
//   sram_rst            synchronous active-high reset
//   mX_req/we/addr/wdata  requester X command. req is held until gnt is seen.
//   mX_gnt              one-cycle grant; the request fields were latched
//   mX_rdata/mX_rvalid  read data, held until the next read for that port
//                       completes; rvalid pulses for one cycle
//   mem_address/wdata   SRAM address and write data
//   mem_rdata           SRAM read data
//   mem_cs/we/oe        SRAM chip select, write enable, output enable
//   mem_oe_r            SRAM registered read-done strobe
//   rd_err              sticky flag: a read response came without mem_oe_r
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int data_width    = 32,
  parameter int address_width = 13
) (
  input  logic                     sram_clk,
  input  logic                     sram_rst,

  input  logic                     m0_req,
  input  logic                     m0_we,
  input  logic [address_width-1:0] m0_addr,
  input  logic [data_width-1:0]    m0_wdata,
  output logic                     m0_gnt,
  output logic [data_width-1:0]    m0_rdata,
  output logic                     m0_rvalid,

  input  logic                     m1_req,
  input  logic                     m1_we,
  input  logic [address_width-1:0] m1_addr,
  input  logic [data_width-1:0]    m1_wdata,
  output logic                     m1_gnt,
  output logic [data_width-1:0]    m1_rdata,
  output logic                     m1_rvalid,

  output logic [address_width-1:0] mem_address,
  output logic [data_width-1:0]    mem_wdata,
  input  logic [data_width-1:0]    mem_rdata,
  output logic                     mem_cs,
  output logic                     mem_we,
  output logic                     mem_oe,
  input  logic                     mem_oe_r,

  output logic                     rd_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                   state_q;
  logic                     winner_q;   // 0 = m0, 1 = m1
  logic                     we_q;
  logic                     m0_gnt_q;
  logic                     m1_gnt_q;
  logic                     m0_rvalid_q;
  logic                     m1_rvalid_q;
  logic [data_width-1:0]    m0_rdata_q;
  logic [data_width-1:0]    m1_rdata_q;
  logic [address_width-1:0] mem_address_q;
  logic [data_width-1:0]    mem_wdata_q;
  logic                     mem_cs_q;
  logic                     mem_we_q;
  logic                     mem_oe_q;
  logic                     rd_err_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic                     last_gnt_q;
`endif

  logic                     any_req;
  logic                     winner_d;
  logic                     sel_we;
  logic [address_width-1:0] sel_addr;
  logic [data_width-1:0]    sel_wdata;

  // Winner selection. This is only acted on in IDLE, so a request that is
  // still held during CMD/RESP is never granted twice.
  always_comb begin
    winner_d = 1'b0;
    if (m0_req && m1_req) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      winner_d = 1'b0;
`else
      // On a tie, the requester that was not granted last time wins.
      winner_d = ~last_gnt_q;
`endif
    end else if (m1_req) begin
      winner_d = 1'b1;
    end
  end

  assign any_req   = m0_req | m1_req;
  assign sel_we    = winner_d ? m1_we    : m0_we;
  assign sel_addr  = winner_d ? m1_addr  : m0_addr;
  assign sel_wdata = winner_d ? m1_wdata : m0_wdata;

  // Sequencer. All outputs are registered. The SRAM controls for a cycle are
  // therefore loaded on the edge that enters that cycle's state.
  always_ff @(posedge sram_clk) begin
    if (sram_rst) begin
      state_q       <= IDLE;
      winner_q      <= 1'b0;
      we_q          <= 1'b0;
      m0_gnt_q      <= 1'b0;
      m1_gnt_q      <= 1'b0;
      m0_rvalid_q   <= 1'b0;
      m1_rvalid_q   <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_cs_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_oe_q      <= 1'b0;
      rd_err_q      <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_gnt_q    <= 1'b1;
`endif
    end else begin
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          mem_cs_q <= 1'b0;
          mem_we_q <= 1'b0;
          mem_oe_q <= 1'b0;
          if (any_req) begin
            winner_q      <= winner_d;
            we_q          <= sel_we;
            mem_address_q <= sel_addr;
            mem_wdata_q   <= sel_wdata;
            m0_gnt_q      <= ~winner_d;
            m1_gnt_q      <= winner_d;
            mem_cs_q      <= 1'b1;
            mem_we_q      <= sel_we;
            mem_oe_q      <= ~sel_we;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_gnt_q    <= winner_d;
`endif
            state_q       <= CMD;
          end
        end

        CMD: begin
          if (we_q) begin
            mem_cs_q <= 1'b0;
            mem_we_q <= 1'b0;
            mem_oe_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            // Keep the SRAM output driver enabled while the data is returned.
            mem_cs_q <= 1'b1;
            mem_we_q <= 1'b0;
            mem_oe_q <= 1'b1;
            state_q  <= RESP;
          end
        end

        RESP: begin
          mem_cs_q <= 1'b0;
          mem_we_q <= 1'b0;
          mem_oe_q <= 1'b0;
          state_q  <= IDLE;
          // Only the winner's read data register is updated. The other
          // port's data is left untouched.
          if (mem_oe_r) begin
            if (winner_q) begin
              m1_rdata_q  <= mem_rdata;
              m1_rvalid_q <= 1'b1;
            end else begin
              m0_rdata_q  <= mem_rdata;
              m0_rvalid_q <= 1'b1;
            end
          end else begin
            rd_err_q <= 1'b1;
          end
        end

        default: begin
          mem_cs_q <= 1'b0;
          mem_we_q <= 1'b0;
          mem_oe_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign m0_gnt      = m0_gnt_q;
  assign m1_gnt      = m1_gnt_q;
  assign m0_rvalid   = m0_rvalid_q;
  assign m1_rvalid   = m1_rvalid_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_cs      = mem_cs_q;
  assign mem_we      = mem_we_q;
  assign mem_oe      = mem_oe_q;
  assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Drives sram_arbiter with two requester drivers and a behavioural SRAM.
// Drivers push each issued command into a per-requester stimulus queue.
// A monitor does the following on every falling edge:
//   - pops the stimulus queue when a grant appears
//   - checks that the grant went to the correct requester, in the correct
//     cycle
//   - checks the SRAM command on the bus
//   - applies the command to a reference memory
//   - pushes the expected read data and its due cycle into a response queue
// The response queues are popped and compared whenever rvalid is seen.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 13;
  localparam int DEPTH = 8192;

  logic          sram_clk;
  logic          sram_rst;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_cs, mem_we, mem_oe, mem_oe_r, rd_err;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } stim_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rdExp_t;

  int            assertCount = 0;
  int            failCount   = 0;
  int            cycle       = 0;
  stim_t         stimQ [2][$];
  rdExp_t        rdQ   [2][$];
  int            pendStart [2];
  logic [DW-1:0] held [2];
  logic [DW-1:0] refMem [DEPTH];
  int            lastGnt;
  int            nextIdle;
  int            respDue;
  logic [AW-1:0] respAddr;
  int            resetEpoch = 0;
  int            seenEpoch  = 0;
  bit            inReset;
  bit            forceOeLow;

  sram_arbiter #(
    .data_width    (DW),
    .address_width (AW)
  ) dut (
    .sram_clk    (sram_clk),
    .sram_rst    (sram_rst),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_gnt      (m0_gnt),
    .m0_rdata    (m0_rdata),
    .m0_rvalid   (m0_rvalid),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_gnt      (m1_gnt),
    .m1_rdata    (m1_rdata),
    .m1_rvalid   (m1_rvalid),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_cs      (mem_cs),
    .mem_we      (mem_we),
    .mem_oe      (mem_oe),
    .mem_oe_r    (mem_oe_r),
    .rd_err      (rd_err)
  );

  initial begin
    sram_clk = 1'b0;
    forever #5 sram_clk = ~sram_clk;
  end

  always @(posedge sram_clk) cycle <= cycle + 1;

  // Power-up contents, shared by the SRAM model and the reference memory.
  function automatic logic [DW-1:0] initWord(input int i);
    case (i)
      1:       return 32'h0000_0011;
      2:       return 32'h0000_0022;
      8191:    return 32'hA5A5_A5A5;
      default: return 32'(i) * 32'h9E37_79B1;
    endcase
  endfunction

  // Behavioural synchronous SRAM. A read command is registered, and then
  // presented with mem_oe_r in the following cycle.
  logic [DW-1:0] sramMem [DEPTH];
  bit sramLoaded = 1'b0;
  always @(posedge sram_clk) begin
    if (!sramLoaded) begin
      for (int i = 0; i < DEPTH; i++) sramMem[i] <= initWord(i);
      sramLoaded <= 1'b1;
    end else if (mem_cs && mem_we) begin
      sramMem[mem_address] <= mem_wdata;
    end
    if (mem_cs && mem_oe && !mem_we) mem_rdata <= sramMem[mem_address];
    mem_oe_r <= mem_cs && mem_oe && !mem_we && !forceOeLow;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sram_clk);
      #1;
    end
  endtask

  // Issue one request from requester m and hold it until the grant is seen.
  // Called and returns at one time unit after a rising edge.
  task automatic applyStimulus(input int m, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic  got = 1'b0;
    stim_t tx;
    tx.we   = we;
    tx.addr = addr;
    tx.data = data;
    stimQ[m].push_back(tx);
    pendStart[m] = cycle;
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = data;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = data;
    end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge sram_clk);
      got = (m == 0) ? (m0_gnt === 1'b1) : (m1_gnt === 1'b1);
    end
    if (!got) begin
      checkOutput($sformatf("m%0d_gnt_timeout", m), 32'(got), 32'd1);
      if (stimQ[m].size() > 0) void'(stimQ[m].pop_back());
    end
    @(posedge sram_clk);
    #1;
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    pendStart[m] = -1;
  endtask

  task automatic resetDut();
    sram_rst = 1'b1;
    inReset  = 1'b1;
    resetEpoch++;
    idle(2);
    sram_rst = 1'b0;
    inReset  = 1'b0;
  endtask

  task automatic flushModel();
    seenEpoch = resetEpoch;
    for (int p = 0; p < 2; p++) begin
      rdQ[p].delete();
      held[p] = '0;
    end
    lastGnt  = 1;
    nextIdle = cycle;
    respDue  = -1;
  endtask

  // Checks for the grant and the SRAM bus in one cycle. The arbiter decides
  // in the first cycle it is free and someone requests. Read responses
  // follow one cycle after the command.
  task automatic monitorBus();
    int    w, other, earliest, arb, expW;
    stim_t tx;
    checkOutput("gnt_onehot", 32'(m0_gnt & m1_gnt), 32'd0);
    if (m0_gnt || m1_gnt) begin
      w     = m0_gnt ? 0 : 1;
      other = 1 - w;
      checkOutput($sformatf("m%0d_gnt_pending", w), 32'(pendStart[w] >= 0), 32'd1);
      if (pendStart[w] >= 0 && stimQ[w].size() > 0) begin
        earliest = pendStart[w];
        if (pendStart[other] >= 0 && pendStart[other] < earliest) earliest = pendStart[other];
        arb = (nextIdle > earliest) ? nextIdle : earliest;
        checkOutput($sformatf("m%0d_gnt_cycle", w), 32'(cycle), 32'(arb + 1));
        if (pendStart[other] >= 0 && pendStart[other] <= cycle - 1) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
          expW = 0;
`else
          expW = 1 - lastGnt;
`endif
          checkOutput("tie_winner", 32'(w), 32'(expW));
        end
        tx = stimQ[w].pop_front();
        checkOutput("cmd_cs", 32'(mem_cs), 32'd1);
        checkOutput("cmd_we", 32'(mem_we), 32'(tx.we));
        checkOutput("cmd_oe", 32'(mem_oe), 32'(!tx.we));
        checkOutput("cmd_addr", 32'(mem_address), 32'(tx.addr));
        if (tx.we) begin
          checkOutput("cmd_wdata", mem_wdata, tx.data);
          refMem[tx.addr] = tx.data;
          nextIdle = cycle + 1;
        end else begin
          if (!forceOeLow) rdQ[w].push_back('{data: refMem[tx.addr], due: cycle + 2});
          respDue  = cycle + 1;
          respAddr = tx.addr;
          nextIdle = cycle + 2;
        end
        lastGnt = w;
      end
    end else if (cycle == respDue) begin
      checkOutput("resp_cs", 32'(mem_cs), 32'd1);
      checkOutput("resp_oe", 32'(mem_oe), 32'd1);
      checkOutput("resp_we", 32'(mem_we), 32'd0);
      checkOutput("resp_addr", 32'(mem_address), 32'(respAddr));
    end else begin
      checkOutput("idle_ctrl", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    end
  endtask

  task automatic monitorRead(input int p, input logic rv, input logic [DW-1:0] rd);
    rdExp_t e;
    if (rv === 1'b1) begin
      if (rdQ[p].size() == 0) begin
        checkOutput($sformatf("m%0d_rvalid_spurious", p), 32'(rv), 32'd0);
      end else begin
        e = rdQ[p].pop_front();
        checkOutput($sformatf("m%0d_rvalid_cycle", p), 32'(cycle), 32'(e.due));
        checkOutput($sformatf("m%0d_rdata", p), rd, e.data);
        held[p] = e.data;
      end
    end else begin
      if (rdQ[p].size() > 0 && rdQ[p][0].due < cycle) begin
        checkOutput($sformatf("m%0d_rvalid_missing", p), 32'(rv), 32'd1);
        void'(rdQ[p].pop_front());
      end
      checkOutput($sformatf("m%0d_rdata_hold", p), rd, held[p]);
    end
  endtask

  // Scoreboard monitor
  initial begin
    for (int i = 0; i < DEPTH; i++) refMem[i] = initWord(i);
    forever begin
      @(negedge sram_clk);
      if (!inReset) begin
        if (resetEpoch != seenEpoch) flushModel();
        monitorBus();
        monitorRead(0, m0_rvalid, m0_rdata);
        monitorRead(1, m1_rvalid, m1_rdata);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drain();
    for (int i = 0; i < 20 && (rdQ[0].size() + rdQ[1].size()) > 0; i++) idle(1);
    checkOutput("drain_pending", 32'(rdQ[0].size() + rdQ[1].size()), 32'd0);
  endtask

  initial begin
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    forceOeLow   = 1'b0;
    pendStart[0] = -1;
    pendStart[1] = -1;
    resetDut();

    // Reset state
    checkOutput("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    checkOutput("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    checkOutput("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    checkOutput("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    checkOutput("rst_ctrl", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    checkOutput("rst_rd_err", 32'(rd_err), 32'd0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
    checkOutput("rst_m1_rdata", m1_rdata, 32'd0);
    checkOutput("rst_mem_address", 32'(mem_address), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);

    // Write followed by a read-back on m0
    applyStimulus(0, 1'b1, 13'h0010, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 13'h0010, 32'h0);
    idle(2);
    checkOutput("wr_rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);

    // Simultaneous reads after reset: m0 is served first
    resetDut();
    fork
      applyStimulus(0, 1'b0, 13'h0001, 32'h0);
      applyStimulus(1, 1'b0, 13'h0002, 32'h0);
    join
    idle(3);
    checkOutput("tie_m0_rdata", m0_rdata, 32'h0000_0011);
    checkOutput("tie_m1_rdata", m1_rdata, 32'h0000_0022);

    // Continuous writes from both requesters
    fork
      for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 13'(13'h0100 + i), $urandom);
      for (int i = 0; i < 4; i++) applyStimulus(1, 1'b1, 13'(13'h0200 + i), $urandom);
    join

    // Top address read on m1 while m0 is quiet
    applyStimulus(1, 1'b0, 13'h1FFF, 32'h0);
    idle(3);
    checkOutput("top_m1_rdata", m1_rdata, 32'hA5A5_A5A5);

    // Read with the SRAM strobe suppressed
    forceOeLow = 1'b1;
    applyStimulus(0, 1'b0, 13'h0005, 32'h0);
    idle(2);
    forceOeLow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("rd_err_set", 32'(rd_err), 32'd1);
      idle(1);
    end

    // Random traffic from both requesters
    fork
      for (int i = 0; i < 30; i++) begin
        idle($urandom_range(0, 3));
        applyStimulus(0, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? 13'($urandom_range(0, DEPTH - 1)) : 13'($urandom_range(0, 7)),
                      $urandom);
      end
      for (int i = 0; i < 30; i++) begin
        idle($urandom_range(0, 3));
        applyStimulus(1, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? 13'($urandom_range(0, DEPTH - 1)) : 13'($urandom_range(0, 7)),
                      $urandom);
      end
    join
    drain();
    checkOutput("rd_err_sticky", 32'(rd_err), 32'd1);

    // Reset during the response cycle of an m0 read
    applyStimulus(0, 1'b0, 13'h0007, 32'h0);
    sram_rst = 1'b1;
    inReset  = 1'b1;
    resetEpoch++;
    idle(1);
    sram_rst = 1'b0;
    checkOutput("abort_m0_rvalid", 32'(m0_rvalid), 32'd0);
    checkOutput("abort_ctrl", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    checkOutput("abort_m0_rdata", m0_rdata, 32'd0);
    checkOutput("abort_rd_err", 32'(rd_err), 32'd0);
    inReset = 1'b0;
    idle(1);

    // Normal service after the aborted transaction
    applyStimulus(0, 1'b1, 13'h0033, 32'h1234_5678);
    applyStimulus(0, 1'b0, 13'h0033, 32'h0);
    idle(2);
    checkOutput("post_abort_m0_rdata", m0_rdata, 32'h1234_5678);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-port 8k x 32 synchronous SRAM.
- Accepts read/write requests from two masters (m0 = boot loader, m1 = core), issues cs/we/oe command cycles to the SRAM, and captures read data using the SRAM's sram_oe_r strobe.
- Returns read data per requester with a one-cycle rvalid pulse.

Parameters:
- data_width, 32, SRAM/requester data width
- address_width, 13, SRAM word address width

Ports:
- sram_clk  input  1  clock; also clocks the SRAM
- sram_rst  input  1  synchronous reset, active-high
- m0_req  input  1  requester 0 request; held until m0_gnt sampled high
- m0_we  input  1  1 = write, 0 = read
- m0_addr  input  address_width  word address
- m0_wdata  input  data_width  write data
- m0_gnt  output  1  one-cycle grant; request fields are latched
- m0_rdata  output  data_width  read data; held until next m0 read completes
- m0_rvalid  output  1  one-cycle pulse, m0_rdata valid
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: same as m0_*
- mem_address  output  address_width  to SRAM address
- mem_wdata  output  data_width  to SRAM data in
- mem_rdata  input  data_width  from SRAM data out
- mem_cs  output  1  SRAM chip select
- mem_we  output  1  SRAM write enable
- mem_oe  output  1  SRAM output enable
- mem_oe_r  input  1  SRAM registered read-done strobe
- rd_err  output  1  sticky: RESP state reached with mem_oe_r low

Behaviour:
- Reset (synchronous): state IDLE; all gnt/rvalid/mem_cs/mem_we/mem_oe/rd_err = 0; mem_address, mem_wdata, m0_rdata, m1_rdata = 0; last_gnt = 1, so m0 wins the first tie. Reset mid-operation aborts the transaction without an rvalid.
- FSM states:
  - IDLE: mem_cs/we/oe = 0; mem_address/mem_wdata hold their last values.
    - Any req: pick winner, latch addr/we/wdata, set winner gnt for the next cycle, go to CMD.
    - No req: stay in IDLE.
  - CMD (1 cycle): gnt[winner] = 1; mem_cs = 1; mem_we = latched we; mem_oe = !latched we; address/wdata driven from latches.
    - Write: goes to IDLE.
    - Read: goes to RESP.
  - RESP (1 cycle): mem_cs = 1, mem_oe = 1, mem_we = 0, same address. This keeps the SRAM tri-state driver enabled.
    - mem_oe_r = 1: capture mem_rdata into winner rdata; winner rvalid = 1 next cycle.
    - mem_oe_r = 0: no capture, no rvalid, rd_err set.
    - Always goes to IDLE.
- Arbitration: only one req → that requester wins. Both → the requester not equal to last_gnt wins. last_gnt updates on every grant.
- Handshake: requester drops or changes req on the edge where it samples gnt = 1. Arbitration occurs only in IDLE, so a held req is never double-granted.
- Timing, relative to req first seen in IDLE at cycle N:
  - gnt in N+1.
  - Write lands at the end of N+1; arbiter back in IDLE at N+2.
  - Read: rvalid in N+3.
  - Maximum throughput: write every 2 cycles, read every 3.
- Any new req arriving while not in IDLE waits. Requests are never dropped.
- rdata of the non-winning port is never modified.

Optional Feature:
- SRAM_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, m0 always wins a tie; last_gnt is unused.
  - Undefined: round-robin as above.

Test Plan:
- Reset, then m0 write addr 0x0010 data 0xDEADBEEF, then m0 read 0x0010 → write: m0_gnt 1 cycle after req, mem_cs = mem_we = 1 in the gnt cycle. Read: m0_rvalid 2 cycles after m0_gnt, m0_rdata = 0xDEADBEEF.
- m0 and m1 both request reads in the same cycle after reset (addr 0x0001 = 0x11, 0x0002 = 0x22 preloaded) → m0 granted first; m1 gnt exactly 3 cycles later; m0_rdata = 0x11, m1_rdata = 0x22.
- Both requesters hold continuous writes for 8 grants → gnt alternates m0, m1, m0, … with a grant every 2 cycles. With SRAM_ARB_FIXED_PRIO_EN: m1 never granted while m0_req is high.
- m1 read of 0x1FFF (top address) = 0xA5A5A5A5 while m0 is idle → m1_rvalid pulse width 1, m1_rdata = 0xA5A5A5A5, m0_rdata unchanged, m0_rvalid stays 0.
- sram_rst asserted in RESP of an m0 read → next cycle: state IDLE, no m0_rvalid, all mem_* controls 0, m0_rdata = 0; a following m0 request is granted normally.
- SRAM model forced to hold mem_oe_r = 0 during a read → no rvalid; rd_err = 1 and stays 1 until sram_rst.
